pulse_timer: RTL and testbench

Measures the high and low phase widths of the conditioned input line, in clock-enable ticks. It consumes the edge strobes from the front-end (`edges_t`) and the `count_enable` tick, the same signals the enable generator sees. On each completed high+low period it emits one record over a valid/ready handshake to the downstream decoder. It sits directly downstream of `count_enable`.

---
 rtl/pulse_timer.sv | 212 +++++++++++++++++++++
 tb/tb_pulse_timer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_timer.sv
// pulse_timer: measures the high and low phase widths of the conditioned input line.
//
// The widths are counted in count-enable ticks. The block uses the front-end edge strobes
// and the count_enable tick. Each completed high+low period produces one record. A record
// is also produced when the low phase saturates, and that record is flagged as a timeout.
// Records leave the block over a registered valid/ready handshake.
//
// Ports:
//   i_clk           clock
//   i_reset_n       asynchronous active-low reset
//   i_edges         single-cycle rising/falling strobes (pipeline_types::edges_t)
//   i_count_enable  single-cycle measurement tick
//   i_ready         downstream accepts the pending record
//   o_valid         record available
//   o_high          high-phase width in ticks
//   o_low           low-phase width in ticks
//   o_timeout       record was closed by low-phase saturation, not by a rising edge
//   o_overrun       sticky: a record was dropped because the output slot was occupied

package pipeline_types;
  typedef struct packed {
    logic rising;
    logic falling;
  } edges_t;
endpackage

module pulse_timer
  import pipeline_types::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  edges_t             i_edges,
  input  logic               i_count_enable,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [COUNT_W-1:0] o_high,
  output logic [COUNT_W-1:0] o_low,
  output logic               o_timeout,
  output logic               o_overrun
);

  localparam logic [COUNT_W-1:0] MaxCnt  = '1;
  localparam logic [COUNT_W-1:0] ZeroCnt = '0;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

  // Saturating increment; never wraps past MaxCnt.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                 input logic               inc);
    if (inc && (v != MaxCnt)) begin
      return v + COUNT_W'(1);
    end
    return v;
  endfunction

  // Measurement state
  state_e             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] high_cap_q, high_cap_d;

  // Output slot
  logic               valid_q, valid_d;
  logic [COUNT_W-1:0] high_q, high_d;
  logic [COUNT_W-1:0] low_q, low_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;

  // Qualified strobes: a simultaneous rising+falling pair is a glitch and is dropped.
  logic               glitch;
  logic               rise;
  logic               fall;
  logic               tick;
  // Counter value including this cycle's tick; a coincident tick belongs to the closing phase.
  logic [COUNT_W-1:0] cnt_ext;

  // Record produced by the measurement FSM this cycle
  logic               emit;
  logic [COUNT_W-1:0] emit_low;
  logic               emit_timeout;

  assign glitch  = i_edges.rising & i_edges.falling;
  assign rise    = i_edges.rising & ~glitch;
  assign fall    = i_edges.falling & ~glitch;
  assign tick    = i_count_enable;
  assign cnt_ext = sat_inc(cnt_q, tick);

  //--------------------------------------------------------------------------
  // Measurement FSM: next state and record generation
  //--------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    high_cap_d   = high_cap_q;
    emit         = 1'b0;
    emit_low     = ZeroCnt;
    emit_timeout = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Ticks are ignored until the first rising edge opens a high phase.
        if (rise) begin
          cnt_d   = ZeroCnt;
          state_d = StHigh;
        end
      end

      StHigh: begin
        if (fall) begin
          high_cap_d = cnt_ext;
          cnt_d      = ZeroCnt;
          state_d    = StLow;
        end else if (rise) begin
          // The falling edge was missed. Restart the high phase without emitting a record.
          cnt_d = ZeroCnt;
        end else begin
          // The high phase saturates quietly and never times out.
          cnt_d = cnt_ext;
        end
      end

      StLow: begin
        if (rise) begin
          // This edge closes the period and opens the next high phase.
          emit     = 1'b1;
          emit_low = cnt_ext;
          cnt_d    = ZeroCnt;
          state_d  = StHigh;
        end else if (tick && (cnt_ext == MaxCnt)) begin
          emit         = 1'b1;
          emit_low     = MaxCnt;
          emit_timeout = 1'b1;
          cnt_d        = ZeroCnt;
          state_d      = StIdle;
        end else begin
          // A falling edge while low is ignored.
          cnt_d = cnt_ext;
        end
      end

      default: begin
        cnt_d   = ZeroCnt;
        state_d = StIdle;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Output slot: one registered record with a valid/ready handshake
  //--------------------------------------------------------------------------
  always_comb begin
    valid_d   = valid_q;
    high_d    = high_q;
    low_d     = low_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    if (emit) begin
      if (!valid_q || i_ready) begin
        // The slot is empty or drains this cycle, so back-to-back loading is allowed.
        valid_d   = 1'b1;
        high_d    = high_cap_q;
        low_d     = emit_low;
        timeout_d = emit_timeout;
      end else begin
        // The pending record wins. Drop the new one and flag it until reset.
        overrun_d = 1'b1;
      end
    end
  end

  //--------------------------------------------------------------------------
  // State registers
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= ZeroCnt;
      high_cap_q <= ZeroCnt;
      valid_q    <= 1'b0;
      high_q     <= ZeroCnt;
      low_q      <= ZeroCnt;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_cap_q <= high_cap_d;
      valid_q    <= valid_d;
      high_q     <= high_d;
      low_q      <= low_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_high    = high_q;
  assign o_low     = low_q;
  assign o_timeout = timeout_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_pulse_timer.sv
// Testbench for pulse_timer. It runs directed scenarios and then randomized stimulus.
// All outputs are checked every cycle against a period-level reference model.
module tb_pulse_timer;
  import pipeline_types::*;

  localparam int unsigned CW   = 4;
  localparam int          MaxV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  edges_t        edges;
  logic          tick;
  logic          ready;
  logic          o_valid;
  logic [CW-1:0] o_high;
  logic [CW-1:0] o_low;
  logic          o_timeout;
  logic          o_overrun;

  pulse_timer #(.COUNT_W(CW)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_edges       (edges),
    .i_count_enable(tick),
    .i_ready       (ready),
    .o_valid       (o_valid),
    .o_high        (o_high),
    .o_low         (o_low),
    .o_timeout     (o_timeout),
    .o_overrun     (o_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: tracks which phase of the waveform is being measured.
  // 0 = no period open, 1 = measuring high, 2 = measuring low.
  int m_phase, m_cnt, m_hcap;
  bit e_valid, e_timeout, e_overrun;
  int e_high, e_low;

  function automatic int sat(input int v);
    return (v > MaxV) ? MaxV : v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_hcap = 0;
    e_valid = 0; e_timeout = 0; e_overrun = 0; e_high = 0; e_low = 0;
  endtask

  task automatic model_clock(input bit r, input bit f, input bit t, input bit rdy);
    bit rr, ff, emit, to;
    int width, lw;
    rr = r && !f;
    ff = f && !r;
    width = sat(m_cnt + int'(t));
    emit = 0; lw = 0; to = 0;
    case (m_phase)
      0: if (rr) begin m_cnt = 0; m_phase = 1; end
      1: begin
        if (ff) begin m_hcap = width; m_cnt = 0; m_phase = 2; end
        else if (rr) m_cnt = 0;
        else m_cnt = width;
      end
      default: begin
        if (rr) begin emit = 1; lw = width; m_cnt = 0; m_phase = 1; end
        else if (t && width == MaxV) begin emit = 1; lw = MaxV; to = 1; m_cnt = 0; m_phase = 0; end
        else m_cnt = width;
      end
    endcase
    if (emit) begin
      if (!e_valid || rdy) begin
        e_valid = 1; e_high = m_hcap; e_low = lw; e_timeout = to;
      end else begin
        e_overrun = 1;
      end
    end else if (e_valid && rdy) begin
      e_valid = 0;
    end
  endtask

  task automatic compare_all();
    check("valid", 32'(o_valid), 32'(e_valid));
    check("high", 32'(o_high), e_high);
    check("low", 32'(o_low), e_low);
    check("timeout", 32'(o_timeout), 32'(e_timeout));
    check("overrun", 32'(o_overrun), 32'(e_overrun));
  endtask

  // Applies inputs for one cycle. Call it 1 time unit after a rising clock edge.
  task automatic step(input bit r, input bit f, input bit t);
    edges.rising = r; edges.falling = f; tick = t;
    @(posedge clk);
    model_clock(r, f, t, ready);
    #1;
    compare_all();
    edges = '0; tick = 1'b0;
  endtask

  // Pulses the reset between clock edges and checks that the outputs clear at once.
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_high"}, 32'(o_high), 0);
    check({tag, "_low"}, 32'(o_low), 0);
    check({tag, "_timeout"}, 32'(o_timeout), 0);
    check({tag, "_overrun"}, 32'(o_overrun), 0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; edges = '0; tick = 1'b0; ready = 1'b1;
    model_reset();
    #2;
    compare_all();
    #14 rst_n = 1'b1;  // posedge at 15, so this is 1 after the edge

    // Basic period: high 3 ticks, low 2 ticks
    step(1, 0, 0);
    repeat (3) step(0, 0, 1);
    step(0, 1, 0);
    repeat (2) step(0, 0, 1);
    step(1, 0, 0);
    check("tp1_valid", 32'(o_valid), 1);
    check("tp1_high", 32'(o_high), 3);
    check("tp1_low", 32'(o_low), 2);
    check("tp1_timeout", 32'(o_timeout), 0);

    // Falling edge coincident with the 4th high tick, then an empty low phase
    repeat (3) step(0, 0, 1);
    step(0, 1, 1);
    step(1, 0, 0);
    check("tp2_high", 32'(o_high), 4);
    check("tp2_low", 32'(o_low), 0);

    // Low-phase saturation timeout
    step(0, 1, 0);
    repeat (MaxV - 1) step(0, 0, 1);
    check("tp3_pre_valid", 32'(o_valid), 0);
    step(0, 0, 1);
    check("tp3_valid", 32'(o_valid), 1);
    check("tp3_low", 32'(o_low), MaxV);
    check("tp3_timeout", 32'(o_timeout), 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 0, 1);
    check("tp3_idle_quiet", 32'(o_valid), 0);

    // Backpressure across two periods
    ready = 1'b0;
    step(1, 0, 0); step(0, 0, 1); step(0, 1, 0); step(0, 0, 1); step(1, 0, 0);
    repeat (2) step(0, 0, 1);
    step(0, 1, 0);
    repeat (3) step(0, 0, 1);
    step(1, 0, 0);
    check("tp4_held_high", 32'(o_high), 1);
    check("tp4_held_low", 32'(o_low), 1);
    check("tp4_overrun", 32'(o_overrun), 1);
    ready = 1'b1;
    step(0, 0, 0);
    check("tp4_drained", 32'(o_valid), 0);
    step(0, 0, 0);
    check("tp4_no_second", 32'(o_valid), 0);

    // Glitch in HIGH with a tick: stays high and counts the tick
    repeat (2) step(0, 0, 1);
    step(1, 1, 1);
    step(0, 0, 1);
    step(0, 1, 0);
    step(1, 0, 0);
    check("tp5_high", 32'(o_high), 4);
    check("tp5_low", 32'(o_low), 0);

    // Asynchronous reset mid-LOW with a pending record
    step(0, 0, 1); step(0, 1, 0); step(0, 0, 1);
    ready = 1'b0;
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 1);
    check("tp6_pending", 32'(o_valid), 1);
    mid_reset("tp6_rst");
    ready = 1'b1;
    step(0, 0, 0);
    repeat (2) step(0, 0, 1);
    step(0, 1, 0); step(0, 0, 1);
    step(1, 0, 0);
    check("tp6_needs_rise", 32'(o_valid), 0);
    repeat (2) step(0, 0, 1);
    step(0, 1, 0); step(0, 0, 1); step(1, 0, 0);
    check("tp6_fresh_high", 32'(o_high), 2);
    check("tp6_fresh_low", 32'(o_low), 1);

    // Randomized stimulus
    for (int i = 0; i < 4000; i++) begin
      ready = (($urandom % 4) != 0) && ((i / 200) % 3 != 2);
      step(($urandom % 7) == 0, ($urandom % 7) == 0, ($urandom % 2) == 0);
      if ($urandom_range(0, 599) == 0) mid_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
